// File: rtl/booth_pkg.sv
// ============================================================================
// Module : booth_pkg
// Brief  : Shared state encoding and width helper for the Booth multiplier.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // One guard bit lets unsigned operands and the most negative signed
    // multiplicand share one datapath.
    function automatic int ext_w(input int width);
        return width + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/booth_step.sv
// ============================================================================
// Module : booth_step
// Brief  : One radix-2 Booth iteration: conditional add/sub, then arithmetic
//          right shift of {A,Q,q_1}.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module booth_step #(
    parameter int E = 9
) (
    input  logic [E-1:0] i_a,
    input  logic [E-1:0] i_q,
    input  logic         i_q_1,
    input  logic [E-1:0] i_m,
    output logic [E-1:0] o_a,
    output logic [E-1:0] o_q,
    output logic         o_q_1
);

    logic [E-1:0] w_sum;

    always_comb begin
        w_sum = i_a;
        case ({i_q[0], i_q_1})
            2'b01:   w_sum = i_a + i_m;
            2'b10:   w_sum = i_a - i_m;
            default: w_sum = i_a;
        endcase
    end

    assign o_a   = {w_sum[E-1], w_sum[E-1:1]};
    assign o_q   = {w_sum[0], i_q[E-1:1]};
    assign o_q_1 = i_q[0];

endmodule

`default_nettype wire

// File: rtl/booth_mult_seq.sv
// ============================================================================
// Module : booth_mult_seq
// Brief  : Sequential radix-2 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH,
//          signed/unsigned per operation, valid/ready on both sides.
//          Optional macro BOOTH_ZERO_SKIP_EN: zero operand bypasses CALC.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    localparam int c_E     = ext_w(WIDTH);
    localparam int c_CNT_W = $clog2(WIDTH + 2);
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(c_E);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(1);

    state_t             r_state;
    logic [c_E-1:0]     r_a;
    logic [c_E-1:0]     r_q;
    logic [c_E-1:0]     r_m;
    logic               r_q_1;
    logic [c_CNT_W-1:0] r_count;

    logic [c_E-1:0]     w_a_nxt;
    logic [c_E-1:0]     w_q_nxt;
    logic               w_q_1_nxt;
    logic [c_E-1:0]     w_m_ext;
    logic [c_E-1:0]     w_q_ext;
    logic               w_skip;

    assign w_m_ext = {signed_mode & multiplicand[WIDTH-1], multiplicand};
    assign w_q_ext = {signed_mode & multiplier[WIDTH-1], multiplier};

`ifdef BOOTH_ZERO_SKIP_EN
    assign w_skip = (multiplicand == '0) || (multiplier == '0);
`else
    assign w_skip = 1'b0;
`endif

    booth_step #(.E(c_E)) u_step (
        .i_a   (r_a),
        .i_q   (r_q),
        .i_q_1 (r_q_1),
        .i_m   (r_m),
        .o_a   (w_a_nxt),
        .o_q   (w_q_nxt),
        .o_q_1 (w_q_1_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_a       <= '0;
            r_q       <= '0;
            r_m       <= '0;
            r_q_1     <= 1'b0;
            r_count   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            product   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (w_skip) begin
                            product   <= '0;
                            out_valid <= 1'b1;
                            r_state   <= DONE;
                        end else begin
                            r_m     <= w_m_ext;
                            r_q     <= w_q_ext;
                            r_a     <= '0;
                            r_q_1   <= 1'b0;
                            r_count <= c_CNT_INIT;
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_a     <= w_a_nxt;
                    r_q     <= w_q_nxt;
                    r_q_1   <= w_q_1_nxt;
                    r_count <= r_count - 1'b1;
                    // Low 2*WIDTH bits of the shifted {A,Q} hold the product.
                    if (r_count == c_CNT_LAST) begin
                        product   <= {w_a_nxt[WIDTH-2:0], w_q_nxt};
                        out_valid <= 1'b1;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_booth_mult_seq.sv
// ============================================================================
// Module : tb_booth_mult_seq
// Brief  : Self-checking bench: directed WIDTH=8 cases plus randomized
//          WIDTH=16 operations against an arithmetic reference.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_booth_mult_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        iv8, ir8, sm8, ov8, or8;
    logic [7:0]  m8, q8;
    logic [15:0] p8;

    logic        iv16, ir16, sm16, ov16, or16;
    logic [15:0] m16, q16;
    logic [31:0] p16;

    int n_checks = 0;
    int n_fail   = 0;

    booth_mult_seq #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
        .signed_mode(sm8), .multiplicand(m8), .multiplier(q8),
        .out_valid(ov8), .out_ready(or8), .product(p8)
    );

    booth_mult_seq #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16),
        .signed_mode(sm16), .multiplicand(m16), .multiplier(q16),
        .out_valid(ov16), .out_ready(or16), .product(p16)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Plain integer product of the operands interpreted in the chosen mode.
    function automatic logic [31:0] ref_mul(input int w, input logic sm,
                                            input logic [15:0] m, input logic [15:0] q);
        longint mv, qv, pr;
        mv = longint'(m);
        qv = longint'(q);
        if (sm && m[w-1]) mv = mv - (longint'(1) << w);
        if (sm && q[w-1]) qv = qv - (longint'(1) << w);
        pr = mv * qv;
        pr = pr & ((longint'(1) << (2 * w)) - 1);
        return pr[31:0];
    endfunction

    function automatic int exp_lat(input int e, input logic [15:0] m, input logic [15:0] q);
`ifdef BOOTH_ZERO_SKIP_EN
        if (m == 16'd0 || q == 16'd0) return 0;
`endif
        return e;
    endfunction

    task automatic accept8(input logic sm, input logic [7:0] m, input logic [7:0] q);
        int k = 0;
        while (!ir8 && k < 50) begin @(posedge clk); #1; k++; end
        check("in_ready8_wait", {63'd0, ir8}, 64'd1);
        sm8 = sm; m8 = m; q8 = q; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
    endtask

    task automatic wait8(output int lat);
        lat = 0;
        while (!ov8 && lat < 100) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic release8;
        or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
        check("out_valid8_drop", {63'd0, ov8}, 64'd0);
    endtask

    task automatic op8(input string tag, input logic sm, input logic [7:0] m,
                       input logic [7:0] q, input logic [15:0] exp);
        int lat;
        accept8(sm, m, q);
        wait8(lat);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat(9, {8'd0, m}, {8'd0, q})));
        check(tag, {48'd0, p8}, {48'd0, exp});
        check({tag, "_model"}, {48'd0, p8}, {32'd0, ref_mul(8, sm, {8'd0, m}, {8'd0, q})});
        release8();
    endtask

    task automatic op16(input logic sm, input logic [15:0] m, input logic [15:0] q);
        int k = 0;
        int lat = 0;
        while (!ir16 && k < 50) begin @(posedge clk); #1; k++; end
        sm16 = sm; m16 = m; q16 = q; iv16 = 1'b1;
        @(posedge clk); #1;
        iv16 = 1'b0;
        m16 = 16'($urandom); q16 = 16'($urandom); sm16 = 1'($urandom);
        while (!ov16 && lat < 100) begin @(posedge clk); #1; lat++; end
        check("rand16_lat", 64'(lat), 64'(exp_lat(17, m, q)));
        check("rand16_prod", {32'd0, p16}, {32'd0, ref_mul(16, sm, m, q)});
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        or16 = 1'b1;
        @(posedge clk); #1;
        or16 = 1'b0;
    endtask

    function automatic logic [15:0] pick16();
        case ($urandom_range(0, 9))
            0: return 16'h0000;
            1: return 16'h8000;
            2: return 16'h7FFF;
            3: return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int lat;
        rst = 1'b1;
        iv8 = 1'b0; sm8 = 1'b0; m8 = '0; q8 = '0; or8 = 1'b0;
        iv16 = 1'b0; sm16 = 1'b0; m16 = '0; q16 = '0; or16 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {63'd0, ir8}, 64'd1);
        check("rst_out_valid", {63'd0, ov8}, 64'd0);
        check("rst_product", {48'd0, p8}, 64'd0);
        rst = 1'b0;

        op8("signed_neg10x13", 1'b1, 8'hF6, 8'h0D, 16'hFF7E);
        op8("signed_min_sq", 1'b1, 8'h80, 8'h80, 16'h4000);
        op8("signed_min_max", 1'b1, 8'h80, 8'h7F, 16'hC080);
        op8("unsigned_ff_sq", 1'b0, 8'hFF, 8'hFF, 16'hFE01);
        op8("unsigned_ffx2", 1'b0, 8'hFF, 8'h02, 16'h01FE);

        // Backpressure with ignored input attempts.
        accept8(1'b1, 8'hF6, 8'h0D);
        check("calc_in_ready", {63'd0, ir8}, 64'd0);
        wait8(lat);
        check("bp_lat", 64'(lat), 64'd9);
        for (int i = 0; i < 5; i++) begin
            iv8 = 1'b1; m8 = 8'h11; q8 = 8'h22; sm8 = 1'b0;
            @(posedge clk); #1;
            check("bp_out_valid", {63'd0, ov8}, 64'd1);
            check("bp_product", {48'd0, p8}, 64'hFF7E);
            check("bp_in_ready", {63'd0, ir8}, 64'd0);
        end
        iv8 = 1'b0;
        release8();
        check("idle_product_hold", {48'd0, p8}, 64'hFF7E);

        // Reset four cycles into CALC.
        accept8(1'b0, 8'hC3, 8'h5A);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_out_valid", {63'd0, ov8}, 64'd0);
        check("abort_product", {48'd0, p8}, 64'd0);
        check("abort_in_ready", {63'd0, ir8}, 64'd1);
        op8("after_abort_3x5", 1'b0, 8'd3, 8'd5, 16'h000F);

        for (int i = 0; i < 1000; i++) begin
            op16(1'($urandom), pick16(), pick16());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
